// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - shared types and request/response bundle between the rv32i core and the RAM arbiter
package ram_arbiter_pkg;
  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_MASK_B = 2'd0,
    RAM_MASK_H = 2'd1,
    RAM_MASK_W = 2'd2
  } ram_mask_e;
endpackage

interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_we;
  ram_mask_e   d_req_mask;

  logic        i_rsp_valid;
  logic        d_rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_wdata, d_req_we, d_req_mask,
    input  i_req_ready, d_req_ready,
    input  i_rsp_valid, d_rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_wdata, d_req_we, d_req_mask,
    output i_req_ready, d_req_ready,
    output i_rsp_valid, d_rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port data RAM arbiter between instruction fetch and load/store
// Data wins by default; a burst counter hands the port to a waiting fetch after MAX_DATA_BURST data grants.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_LENGTH    = 10,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus,
  output logic [31:0]  ram_addr,
  output logic [31:0]  ram_wdata,
  output mem_op_e      ram_mem_op,
  output ram_mask_e    ram_mask,
  input  logic [31:0]  ram_rdata
);

  localparam logic [3:0]  MAX_BURST = 4'(MAX_DATA_BURST);
  localparam logic [31:0] HI_MASK   = ~((32'd1 << ADDR_LENGTH) - 32'd1);

  logic [3:0]  burst_q, burst_d;
  logic        i_rsp_valid_q, i_rsp_valid_d;
  logic        d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant_d, grant_i, granted, legal, go, is_store;
  logic [31:0] sel_addr;
  ram_mask_e   sel_mask;
  logic [31:0] rdata_ext;

  always_comb begin
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    sel_addr = 32'd0;
    sel_mask = RAM_MASK_W;
    legal    = 1'b0;

    // Readys are gated by reset so nothing can be granted, least of all a store.
    if (rst_n) begin
      grant_d = bus.d_req_valid && !(bus.i_req_valid && burst_q == MAX_BURST);
      grant_i = bus.i_req_valid && !grant_d;
    end
    granted = grant_d || grant_i;

    if (grant_d) begin
      sel_addr = bus.d_req_addr;
      sel_mask = bus.d_req_mask;
    end else begin
      sel_addr = bus.i_req_addr;
      sel_mask = RAM_MASK_W;
    end

    legal = ((sel_addr & HI_MASK) == 32'd0)
         && !(sel_mask == RAM_MASK_H && sel_addr[0])
         && !(sel_mask == RAM_MASK_W && sel_addr[1:0] != 2'b00);
    go       = granted && legal;
    is_store = grant_d && bus.d_req_we;

    bus.d_req_ready = grant_d;
    bus.i_req_ready = grant_i;

    ram_addr   = go ? sel_addr : 32'd0;
    ram_mask   = go ? sel_mask : RAM_MASK_W;
    ram_mem_op = (go && is_store) ? MEM_STORE : MEM_LOAD;
    ram_wdata  = bus.d_req_wdata;

    case (sel_mask)
      RAM_MASK_B: rdata_ext = {24'd0, ram_rdata[7:0]};
      RAM_MASK_H: rdata_ext = {16'd0, ram_rdata[15:0]};
      default:    rdata_ext = ram_rdata;
    endcase

    i_rsp_valid_d = grant_i;
    d_rsp_valid_d = grant_d;
    rsp_err_d     = granted && !legal;
    rsp_rdata_d   = (go && !is_store) ? rdata_ext : 32'd0;

    // Fairness window only counts while a fetch is actually waiting.
    burst_d = burst_q;
    if (!bus.i_req_valid || grant_i) begin
      burst_d = 4'd0;
    end else if (grant_d && burst_q != MAX_BURST) begin
      burst_d = burst_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_q       <= 4'd0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
    end else begin
      burst_q       <= burst_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign bus.i_rsp_valid = i_rsp_valid_q;
  assign bus.d_rsp_valid = d_rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural byte RAM
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_init = 1'b1;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  mem_op_e     ram_mem_op;
  ram_mask_e   ram_mask;
  logic [7:0]  mem [0:1023];

  int n_asserts = 0;
  int n_fail = 0;

  ram_arbiter_if bus();

  ram_arbiter #(.ADDR_LENGTH(10), .MAX_DATA_BURST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_mem_op (ram_mem_op),
    .ram_mask   (ram_mask),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Pre-load pattern: byte at address a holds a[7:0] ^ 8'h5A.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (ram_mem_op == MEM_STORE) begin
      mem[ram_addr[9:0]] <= ram_wdata[7:0];
      if (ram_mask != RAM_MASK_B) mem[ram_addr[9:0] + 10'd1] <= ram_wdata[15:8];
      if (ram_mask == RAM_MASK_W) begin
        mem[ram_addr[9:0] + 10'd2] <= ram_wdata[23:16];
        mem[ram_addr[9:0] + 10'd3] <= ram_wdata[31:24];
      end
    end
  end

  always_comb begin
    ram_rdata = {mem[ram_addr[9:0] + 10'd3], mem[ram_addr[9:0] + 10'd2],
                 mem[ram_addr[9:0] + 10'd1], mem[ram_addr[9:0]]};
    if (ram_mask == RAM_MASK_B) ram_rdata = {24'd0, ram_rdata[7:0]};
    else if (ram_mask == RAM_MASK_H) ram_rdata = {16'd0, ram_rdata[15:0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
  endtask

  // One data request: grant-cycle RAM drive, then the registered response.
  task automatic do_data(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input ram_mask_e mask,
                         input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = addr;
    bus.d_req_wdata = wdata;
    bus.d_req_we    = we;
    bus.d_req_mask  = mask;
    #1;
    chk({tag, " ready"}, 32'(bus.d_req_ready), 32'd1);
    chk({tag, " mem_op"}, 32'(ram_mem_op), (we && !exp_err) ? 32'(MEM_STORE) : 32'(MEM_LOAD));
    chk({tag, " ram_addr"}, ram_addr, exp_err ? 32'd0 : addr);
    @(posedge clk);
    #1;
    chk({tag, " d_rsp_valid"}, 32'(bus.d_rsp_valid), 32'd1);
    chk({tag, " i_rsp_valid"}, 32'(bus.i_rsp_valid), 32'd0);
    chk({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
  endtask

  initial begin
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h20;
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h10;
    bus.d_req_wdata = 32'h12345678;
    bus.d_req_we    = 1'b1;
    bus.d_req_mask  = RAM_MASK_W;

    // Requests pending throughout reset must not be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset d_ready", 32'(bus.d_req_ready), 32'd0);
    chk("reset i_ready", 32'(bus.i_req_ready), 32'd0);
    chk("reset mem_op", 32'(ram_mem_op), 32'(MEM_LOAD));
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle i_rsp_valid", 32'(bus.i_rsp_valid), 32'd0);
    chk("idle d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
    chk("idle rdata", bus.rsp_rdata, 32'd0);
    chk("idle err", 32'(bus.rsp_err), 32'd0);
    chk("idle mem_op", 32'(ram_mem_op), 32'(MEM_LOAD));

    // Store, then back-to-back loads see the new data.
    do_data("sw10", 32'h10, 32'hDEADBEEF, 1'b1, RAM_MASK_W, 32'h0, 1'b0);
    do_data("lw10", 32'h10, 32'h0, 1'b0, RAM_MASK_W, 32'hDEADBEEF, 1'b0);
    do_data("lb13", 32'h13, 32'h0, 1'b0, RAM_MASK_B, 32'h000000DE, 1'b0);
    do_data("lh12", 32'h12, 32'h0, 1'b0, RAM_MASK_H, 32'h0000DEAD, 1'b0);

    // Illegal requests: misaligned half, misaligned+out-of-range word, out-of-range word.
    do_data("lh11", 32'h11, 32'h0, 1'b0, RAM_MASK_H, 32'h0, 1'b1);
    do_data("sw402", 32'h402, 32'hCAFEF00D, 1'b1, RAM_MASK_W, 32'h0, 1'b1);
    do_data("sw400", 32'h400, 32'hCAFEF00D, 1'b1, RAM_MASK_W, 32'h0, 1'b1);
    do_data("lw0", 32'h0, 32'h0, 1'b0, RAM_MASK_W, 32'h59585B5A, 1'b0);
    idle();

    // Fetch and load both held valid: D,D,D,D,I repeating.
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h20;
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h40;
    bus.d_req_we    = 1'b0;
    bus.d_req_mask  = RAM_MASK_W;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("burst%0d i_ready", k), 32'(bus.i_req_ready), (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d d_ready", k), 32'(bus.d_req_ready), (k % 5 == 4) ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("burst%0d i_rsp_valid", k), 32'(bus.i_rsp_valid), (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d rdata", k), bus.rsp_rdata, (k % 5 == 4) ? 32'h79787B7A : 32'h19181B1A);
      @(negedge clk);
    end

    // Lone misaligned fetch is rejected on the fetch response.
    bus.d_req_valid = 1'b0;
    bus.i_req_addr  = 32'h22;
    #1;
    chk("fetch22 i_ready", 32'(bus.i_req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("fetch22 i_rsp_valid", 32'(bus.i_rsp_valid), 32'd1);
    chk("fetch22 err", 32'(bus.rsp_err), 32'd1);
    chk("fetch22 rdata", bus.rsp_rdata, 32'd0);
    idle();

    // Reset the cycle after a load grant: the response is dropped.
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h10;
    bus.d_req_we    = 1'b0;
    bus.d_req_mask  = RAM_MASK_W;
    #1;
    chk("pre-reset load ready", 32'(bus.d_req_ready), 32'd1);
    @(negedge clk);
    bus.d_req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
    chk("post-reset rdata", bus.rsp_rdata, 32'd0);

    // Store offered while in reset is never granted.
    @(negedge clk);
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b1;
    bus.d_req_wdata = 32'h12345678;
    #1;
    chk("reset store ready", 32'(bus.d_req_ready), 32'd0);
    chk("reset store mem_op", 32'(ram_mem_op), 32'(MEM_LOAD));
    @(negedge clk);
    bus.d_req_valid = 1'b0;
    rst_n = 1'b1;
    do_data("lw10 after reset", 32'h10, 32'h0, 1'b0, RAM_MASK_W, 32'hDEADBEEF, 1'b0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
